// File: rtl/onehot_demux8.sv
// onehot_demux8 -- registered 1:8 demultiplexer with per-lane holding registers.
//
// One K-bit word plus an 8-bit one-hot select is taken over a valid/ready
// handshake and written into the one-entry holding register of the selected
// lane. Each lane presents its word on its own valid/ready output handshake.
// Words carrying a zero or multi-hot select are always consumed, never
// written to a lane, flagged on sel_err for one cycle and counted.
//
// Handshake rule (both sides): a word moves on a rising clock edge where
// valid and ready are both high; ready never depends on the valid of the
// same interface; a producer may change or withdraw its word while ready is
// low, and nothing is stored until the transfer edge.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input word present
//   in_ready   input word is accepted this cycle (combinational)
//   in_data    K-bit input word
//   in_sel     one-hot destination lane, bit i selects lane i
//   out_valid  bit i: lane i holds a word
//   out_ready  bit i: consumer of lane i takes the word this cycle
//   out_data   lane i on bits [i*K +: K]; holds last value after drain
//   sel_err    one-cycle registered pulse after a malformed select is dropped
//   err_count  saturating count of dropped words
module onehot_demux8 #(
    parameter int K    = 8,
    parameter int ERRW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [K-1:0]     in_data,
    input  logic [7:0]       in_sel,
    output logic [7:0]       out_valid,
    input  logic [7:0]       out_ready,
    output logic [8*K-1:0]   out_data,
    output logic             sel_err,
    output logic [ERRW-1:0]  err_count
);

    logic [7:0]      full_q, full_d;
    logic [K-1:0]    data_q [8];
    logic [K-1:0]    data_d [8];
    logic            sel_err_q, sel_err_d;
    logic [ERRW-1:0] err_q, err_d;

    logic       sel_zero;
    logic       sel_multi;
    logic       onehot;
    logic       bad;
    logic [7:0] lane_open;
    logic       target_open;
    logic [7:0] wr_en;

    // x & (x-1) clears the lowest set bit; anything left means two or more bits.
    assign sel_zero  = (in_sel == 8'h00);
    assign sel_multi = ((in_sel & (in_sel - 8'd1)) != 8'h00);
    assign onehot    = !sel_zero && !sel_multi;
    assign bad       = in_valid && !onehot;

    // A lane can take a word if it is empty or is being drained on this edge.
    // With a one-hot select the AND/OR picks exactly the target lane's bit.
    assign lane_open   = ~full_q | out_ready;
    assign target_open = |(in_sel & lane_open);

    // Malformed selects are always swallowed, so ready is only gated for
    // well-formed ones.
    assign in_ready = onehot ? target_open : 1'b1;

    always_comb begin
        wr_en     = 8'h00;
        full_d    = full_q;
        sel_err_d = 1'b0;
        err_d     = err_q;
        for (int i = 0; i < 8; i++) begin
            data_d[i] = data_q[i];
        end

        if (in_valid && in_ready && onehot) begin
            wr_en = in_sel;
        end

        // Drain first, then refill: a lane drained and written on the same
        // edge stays full with the new word.
        full_d = (full_q & ~out_ready) | wr_en;

        for (int i = 0; i < 8; i++) begin
            if (wr_en[i]) begin
                data_d[i] = in_data;
            end
        end

        sel_err_d = bad;
        if (bad && (err_q != {ERRW{1'b1}})) begin
            err_d = err_q + ERRW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q    <= 8'h00;
            sel_err_q <= 1'b0;
            err_q     <= '0;
            for (int i = 0; i < 8; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            full_q    <= full_d;
            sel_err_q <= sel_err_d;
            err_q     <= err_d;
            for (int i = 0; i < 8; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_valid = full_q;
    assign sel_err   = sel_err_q;
    assign err_count = err_q;

    for (genvar g = 0; g < 8; g++) begin : g_lane
        assign out_data[g*K +: K] = data_q[g];
    end

endmodule
